// File: rtl/mem_port_arbiter_if.sv
// Handshake and RAM-bus bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_done_out;
  logic [31:0]       if_inst_out;

  logic              mem_read_req_in;
  logic              mem_write_req_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [31:0]       mem_val_in;
  logic [2:0]        mem_len_in;
  logic              mem_done_out;
  logic [31:0]       mem_val_read_out;

  logic [1:0]        busy_out;

  logic [7:0]        ram_din_in;
  logic [7:0]        ram_dout_out;
  logic [ADDR_W-1:0] ram_a_out;
  logic              ram_wr_out;

  modport slave (
    input  if_req_in, if_addr_in,
    input  mem_read_req_in, mem_write_req_in, mem_addr_in, mem_val_in, mem_len_in,
    input  ram_din_in,
    output if_done_out, if_inst_out,
    output mem_done_out, mem_val_read_out,
    output busy_out,
    output ram_dout_out, ram_a_out, ram_wr_out
  );

  modport master (
    output if_req_in, if_addr_in,
    output mem_read_req_in, mem_write_req_in, mem_addr_in, mem_val_in, mem_len_in,
    output ram_din_in,
    input  if_done_out, if_inst_out,
    input  mem_done_out, mem_val_read_out,
    input  busy_out,
    input  ram_dout_out, ram_a_out, ram_wr_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port sequencer/arbiter for IF and MEM; MEM has priority.
// Define MEM_PREEMPT_EN to let a MEM request abort an in-flight IF fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_val_q, mem_val_d;

  logic              take_mem;
  logic [1:0]        byte_idx;
  logic [31:0]       rd_word;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_inst_q  <= '0;
      mem_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_inst_q  <= if_inst_d;
      mem_val_q  <= mem_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    if_inst_d  = if_inst_q;
    mem_val_d  = mem_val_q;
    take_mem   = 1'b0;
    byte_idx   = 2'(cnt_q - 3'd2);
    rd_word    = '0;

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          take_mem = bus.mem_write_req_in | bus.mem_read_req_in;
          if (!take_mem && bus.if_req_in) begin
            state_d  = IF_RD;
            base_d   = bus.if_addr_in;
            ram_a_d  = bus.if_addr_in;
            len_d    = 3'd4;
            ram_wr_d = 1'b0;
            cnt_d    = 3'd1;
          end
        end
        IF_RD, MEM_RD: begin
`ifdef MEM_PREEMPT_EN
          take_mem = (state_q == IF_RD) &&
                     (bus.mem_write_req_in | bus.mem_read_req_in);
`endif
          if (!take_mem) begin
            // Address leads capture by two edges: byte cnt-2 lands on edge cnt.
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < len_q)
              ram_a_d = base_q + ADDR_W'(cnt_q);
            if (cnt_q >= 3'd2) begin
              rd_word = (state_q == IF_RD) ? if_inst_q : mem_val_q;
              if (byte_idx == 2'd0)
                rd_word = '0;
              rd_word[{byte_idx, 3'b000} +: 8] = bus.ram_din_in;
              if (state_q == IF_RD) if_inst_d = rd_word;
              else                  mem_val_d = rd_word;
            end
            if (cnt_q == len_q + 3'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
              if (state_q == IF_RD) if_done_d  = 1'b1;
              else                  mem_done_d = 1'b1;
            end
          end
        end
        MEM_WR: begin
          if (cnt_q < len_q) begin
            ram_a_d    = base_q + ADDR_W'(cnt_q);
            ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d      = cnt_q + 3'd1;
          end else begin
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_mem) begin
        cnt_d   = 3'd1;
        base_d  = bus.mem_addr_in;
        ram_a_d = bus.mem_addr_in;
        wdata_d = bus.mem_val_in;
        if (bus.mem_write_req_in) begin
          state_d    = MEM_WR;
          len_d      = bus.mem_len_in + 3'd1;
          ram_dout_d = bus.mem_val_in[7:0];
          ram_wr_d   = 1'b1;
        end else begin
          state_d  = MEM_RD;
          len_d    = bus.mem_len_in;
          ram_wr_d = 1'b0;
        end
      end
    end
  end

  assign bus.busy_out         = {(state_q == MEM_RD) || (state_q == MEM_WR), state_q == IF_RD};
  assign bus.if_done_out      = if_done_q;
  assign bus.if_inst_out      = if_inst_q;
  assign bus.mem_done_out     = mem_done_q;
  assign bus.mem_val_read_out = mem_val_q;
  assign bus.ram_a_out        = ram_a_q;
  assign bus.ram_dout_out     = ram_dout_q;
  assign bus.ram_wr_out       = ram_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous byte-RAM model gated by rdy.
module tb_mem_port_arbiter;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy;

  int nvec = 0;
  int nerr = 0;
  int n, other;

  logic        ld_en = 1'b0;
  logic [15:0] ld_a  = '0;
  logic [7:0]  ld_d  = '0;
  logic [7:0]  ram [0:65535];

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy    (rdy),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ld_en)
      ram[ld_a] <= ld_d;
    else if (rdy) begin
      bus.ram_din_in <= ram[bus.ram_a_out[15:0]];
      if (bus.ram_wr_out)
        ram[bus.ram_a_out[15:0]] <= bus.ram_dout_out;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke_word(input logic [15:0] a, input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) begin
      ld_en = 1'b1;
      ld_a  = a + 16'(i);
      ld_d  = w[8*i +: 8];
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    step();
    ld_en = 1'b0;
  endtask

  // Steps until the wanted done pulse is seen or max edges elapse.
  task automatic run_until(input bit want_mem, input int max, output int cnt, output int oth);
    cnt = 0;
    oth = 0;
    do begin
      step();
      cnt++;
      if (want_mem ? bus.if_done_out : bus.mem_done_out) oth++;
    end while (!(want_mem ? bus.mem_done_out : bus.if_done_out) && cnt < max);
  endtask

  task automatic mem_req(input bit wr, input logic [31:0] a, input logic [31:0] v, input logic [2:0] len);
    bus.mem_write_req_in = wr;
    bus.mem_read_req_in  = !wr;
    bus.mem_addr_in      = a;
    bus.mem_val_in       = v;
    bus.mem_len_in       = len;
  endtask

  task automatic mem_drop();
    bus.mem_write_req_in = 1'b0;
    bus.mem_read_req_in  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    rdy    = 1'b1;
    bus.if_req_in        = 1'b0;
    bus.if_addr_in       = '0;
    bus.mem_read_req_in  = 1'b0;
    bus.mem_write_req_in = 1'b0;
    bus.mem_addr_in      = '0;
    bus.mem_val_in       = '0;
    bus.mem_len_in       = '0;
    bus.ram_din_in       = '0;

    #12;
    chk("rst if_done",  32'(bus.if_done_out), 32'd0);
    chk("rst mem_done", 32'(bus.mem_done_out), 32'd0);
    chk("rst if_inst",  bus.if_inst_out, 32'd0);
    chk("rst mem_val",  bus.mem_val_read_out, 32'd0);
    chk("rst busy",     32'(bus.busy_out), 32'd0);
    chk("rst ram_a",    bus.ram_a_out, 32'd0);
    chk("rst ram_dout", 32'(bus.ram_dout_out), 32'd0);
    chk("rst ram_wr",   32'(bus.ram_wr_out), 32'd0);
    step();
    rst_in = 1'b0;

    poke_word(16'h1000, 32'h0000_0513);
    poke_word(16'h3000, 32'h4433_2211);
    poke_word(16'h4000, 32'hDEAD_BEEF);
    poke_word(16'h5000, 32'h0403_0201);
    poke(16'hFFFF, 8'h34);
    poke(16'h0000, 8'h12);
    poke(16'h7002, 8'h00);
    poke(16'h7003, 8'h00);

    // IF fetch at 0x1000
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h1000;
    step();
    chk("if a0", bus.ram_a_out, 32'h1000);
    chk("if busy", 32'(bus.busy_out), 32'd1);
    step(); chk("if a1", bus.ram_a_out, 32'h1001);
    step(); chk("if a2", bus.ram_a_out, 32'h1002);
    step(); chk("if a3", bus.ram_a_out, 32'h1003);
    step(); chk("if done early", 32'(bus.if_done_out), 32'd0);
    step();
    chk("if done", 32'(bus.if_done_out), 32'd1);
    chk("if inst", bus.if_inst_out, 32'h0000_0513);
    chk("if busy idle", 32'(bus.busy_out), 32'd0);
    bus.if_req_in = 1'b0;
    step();
    chk("if done pulse", 32'(bus.if_done_out), 32'd0);

    // SB 0x2003
    mem_req(1'b1, 32'h2003, 32'hAABB_CCDD, 3'd0);
    step();
    chk("sb wr", 32'(bus.ram_wr_out), 32'd1);
    chk("sb a", bus.ram_a_out, 32'h2003);
    chk("sb dout", 32'(bus.ram_dout_out), 32'hDD);
    chk("sb busy", 32'(bus.busy_out), 32'd2);
    step();
    chk("sb done", 32'(bus.mem_done_out), 32'd1);
    chk("sb wr off", 32'(bus.ram_wr_out), 32'd0);
    mem_drop();
    step();
    chk("sb ram", 32'(ram[16'h2003]), 32'hDD);

    // LW raised at cnt=2 of an IF fetch
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h3000;
    step();
    step();
    mem_req(1'b0, 32'h4000, 32'h0, 3'd4);
`ifdef MEM_PREEMPT_EN
    run_until(1'b1, 12, n, other);
    chk("pre lw edges", 32'(n), 32'd6);
    chk("pre no if_done", 32'(other), 32'd0);
    chk("pre lw val", bus.mem_val_read_out, 32'hDEAD_BEEF);
    mem_drop();
    run_until(1'b0, 12, n, other);
    chk("pre refetch edges", 32'(n), 32'd6);
    chk("pre refetch inst", bus.if_inst_out, 32'h4433_2211);
    bus.if_req_in = 1'b0;
`else
    run_until(1'b0, 12, n, other);
    chk("nopre if edges", 32'(n), 32'd4);
    chk("nopre no mem_done", 32'(other), 32'd0);
    chk("nopre inst", bus.if_inst_out, 32'h4433_2211);
    bus.if_req_in = 1'b0;
    run_until(1'b1, 12, n, other);
    chk("nopre lw edges", 32'(n), 32'd6);
    chk("nopre no if_done", 32'(other), 32'd0);
    chk("nopre lw val", bus.mem_val_read_out, 32'hDEAD_BEEF);
    mem_drop();
`endif

    // LH wrapping past the top of the address space
    step();
    mem_req(1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2);
    step();
    chk("lh a0", bus.ram_a_out, 32'hFFFF_FFFF);
    chk("lh busy", 32'(bus.busy_out), 32'd2);
    step();
    chk("lh a1 wrap", bus.ram_a_out, 32'h0000_0000);
    run_until(1'b1, 8, n, other);
    chk("lh edges", 32'(n), 32'd2);
    chk("lh val", bus.mem_val_read_out, 32'h0000_1234);
    mem_drop();

    // LW at 0x5000 with rdy low for 3 cycles before the byte-1 capture
    step();
    mem_req(1'b0, 32'h5000, 32'h0, 3'd4);
    step(); step(); step();
    rdy = 1'b0;
    step(); step(); step();
    chk("rdy hold a", bus.ram_a_out, 32'h5002);
    chk("rdy hold busy", 32'(bus.busy_out), 32'd2);
    chk("rdy hold done", 32'(bus.mem_done_out), 32'd0);
    rdy = 1'b1;
    run_until(1'b1, 8, n, other);
    chk("rdy edges", 32'(n), 32'd3);
    chk("rdy val", bus.mem_val_read_out, 32'h0403_0201);
    mem_drop();

    // SH then LW read-back
    step();
    mem_req(1'b1, 32'h7000, 32'h1234_BEEF, 3'd1);
    run_until(1'b1, 8, n, other);
    chk("sh edges", 32'(n), 32'd3);
    mem_drop();
    step();
    mem_req(1'b0, 32'h7000, 32'h0, 3'd4);
    run_until(1'b1, 10, n, other);
    chk("sh lw edges", 32'(n), 32'd6);
    chk("sh lw val", bus.mem_val_read_out, 32'h0000_BEEF);
    mem_drop();

    // Reset in the middle of an SW
    step();
    mem_req(1'b1, 32'h6000, 32'h1122_3344, 3'd3);
    step();
    step();
    chk("sw mid wr", 32'(bus.ram_wr_out), 32'd1);
    chk("sw mid a", bus.ram_a_out, 32'h6001);
    #2 rst_in = 1'b1;
    #1;
    chk("rst sw wr", 32'(bus.ram_wr_out), 32'd0);
    chk("rst sw busy", 32'(bus.busy_out), 32'd0);
    chk("rst sw a", bus.ram_a_out, 32'd0);
    chk("rst sw val", bus.mem_val_read_out, 32'd0);
    mem_drop();
    step();
    rst_in = 1'b0;
    run_until(1'b1, 4, n, other);
    chk("rst no done", 32'(n), 32'd4);

    // LB after reset
    mem_req(1'b0, 32'h2003, 32'h0, 3'd1);
    run_until(1'b1, 8, n, other);
    chk("lb edges", 32'(n), 32'd3);
    chk("lb val", bus.mem_val_read_out, 32'h0000_00DD);
    mem_drop();
    step();
    chk("lb done pulse", 32'(bus.mem_done_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
